// File: rtl/mouse_position_tracker.sv
// Purpose: turns raw mouse packets into clamped or wrapped X/Y/Z positions behind an 8-bit register window, with a click counter and an interrupt.
// Latency: packet updates are visible one cycle after PKT_VALID; a bus read drives BUS_DATA in the cycle after its address.
// Backpressure: none. A packet is accepted on any cycle, and a packet that arrives while an interrupt is unacknowledged is counted in MISSED.
module mouse_position_tracker #(
    parameter logic [7:0] BASE_ADDR   = 8'hA0,
    parameter int         POS_W       = 8,
    parameter int         X_LIMIT_DEF = 160,
    parameter int         Y_LIMIT_DEF = 120,
    parameter int         CLICK_MOD   = 4
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         PKT_VALID,
    input  logic [7:0]                   PKT_STATUS,
    input  logic [7:0]                   PKT_DX,
    input  logic [7:0]                   PKT_DY,
    input  logic [3:0]                   PKT_DZ,
    input  logic [7:0]                   BUS_ADDR,
    input  logic                         BUS_WE,
    inout  wire  [7:0]                   BUS_DATA,
    output logic                         BUS_INTERRUPT_RAISE,
    input  logic                         BUS_INTERRUPT_ACK,
    output logic [$clog2(CLICK_MOD)-1:0] CLICK_COUNT
);

    // Two extra bits hold the sign and one doubling of range, so pos +/- 256 cannot overflow.
    localparam int SW = POS_W + 2;
    localparam int CW = $clog2(CLICK_MOD);

    localparam logic [POS_W-1:0] X_LIM_RST = POS_W'(X_LIMIT_DEF);
    localparam logic [POS_W-1:0] Y_LIM_RST = POS_W'(Y_LIMIT_DEF);
    localparam logic [POS_W-1:0] LIM_MIN   = POS_W'(2);
    localparam logic [POS_W-1:0] POS_ONE   = POS_W'(1);
    localparam logic [CW-1:0]    CLICK_TOP = CW'(CLICK_MOD - 1);
    localparam logic [CW-1:0]    CLICK_ONE = CW'(1);

    localparam logic [3:0] OFF_STATUS  = 4'h0;
    localparam logic [3:0] OFF_X_LO    = 4'h1;
    localparam logic [3:0] OFF_X_HI    = 4'h2;
    localparam logic [3:0] OFF_Y_LO    = 4'h3;
    localparam logic [3:0] OFF_Y_HI    = 4'h4;
    localparam logic [3:0] OFF_Z       = 4'h5;
    localparam logic [3:0] OFF_CTRL    = 4'h6;
    localparam logic [3:0] OFF_MISSED  = 4'h7;
    localparam logic [3:0] OFF_XLIM_LO = 4'h8;
    localparam logic [3:0] OFF_XLIM_HI = 4'h9;
    localparam logic [3:0] OFF_YLIM_LO = 4'hA;
    localparam logic [3:0] OFF_YLIM_HI = 4'hB;

    // Architectural state
    logic [POS_W-1:0] x_q, x_d;
    logic [POS_W-1:0] y_q, y_d;
    logic [7:0]       z_q, z_d;
    logic [3:0]       status_q, status_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic [POS_W-1:0] xlim_q, xlim_d;
    logic [POS_W-1:0] ylim_q, ylim_d;
    logic [7:0]       missed_q, missed_d;
    logic [CW-1:0]    click_q, click_d;
    logic             raise_q, raise_d;
    logic             rd_en_q, rd_en_d;
    logic [7:0]       rd_dat_q, rd_dat_d;

    // Bus decode
    logic [7:0] offset;
    logic       in_win;
    logic       wr_en;
    logic       wr_missed;

    // Datapath intermediates
    logic signed [8:0]    dx9, dy9;
    logic signed [SW-1:0] dx_ext, dy_ext;
    logic signed [SW-1:0] x_sum, y_sum;
    logic [POS_W-1:0]     xlim_lo_cand, xlim_hi_cand;
    logic [POS_W-1:0]     ylim_lo_cand, ylim_hi_cand;
    logic [15:0]          x_ext16, y_ext16, xlim_ext16, ylim_ext16;

    // The window wraps modulo 256, so a single subtract covers any BASE_ADDR.
    assign offset    = BUS_ADDR - BASE_ADDR;
    assign in_win    = (offset < 8'd12);
    assign wr_en     = BUS_WE && in_win;
    assign wr_missed = wr_en && (offset[3:0] == OFF_MISSED);

    assign x_ext16    = 16'(x_q);
    assign y_ext16    = 16'(y_q);
    assign xlim_ext16 = 16'(xlim_q);
    assign ylim_ext16 = 16'(ylim_q);

    // Replace the low byte of a limit with bus data.
    function automatic logic [POS_W-1:0] set_lo(input logic [POS_W-1:0] lim, input logic [7:0] dat);
        logic [POS_W-1:0] r;
        r      = lim;
        r[7:0] = dat;
        return r;
    endfunction

    // High-byte writes only reach real bits when the position is wider than a byte.
    if (POS_W > 8) begin : g_lim_hi
        assign xlim_hi_cand = {BUS_DATA[POS_W-9:0], xlim_q[7:0]};
        assign ylim_hi_cand = {BUS_DATA[POS_W-9:0], ylim_q[7:0]};
    end else begin : g_lim_no_hi
        assign xlim_hi_cand = xlim_q;
        assign ylim_hi_cand = ylim_q;
    end

    assign xlim_lo_cand = set_lo(xlim_q, BUS_DATA);
    assign ylim_lo_cand = set_lo(ylim_q, BUS_DATA);

    // Fit a raw result into [0, lim-1]. Wrap mode folds it back once, and the clamp then catches anything still out of range.
    function automatic logic [POS_W-1:0] fit_pos(input logic signed [SW-1:0] r,
                                                 input logic [POS_W-1:0]     lim,
                                                 input logic                 wrap);
        logic signed [SW-1:0] lim_s;
        logic signed [SW-1:0] v;
        lim_s = $signed({2'b00, lim});
        v     = r;
        if (wrap) begin
            if (v[SW-1])
                v = v + lim_s;
            else if (v >= lim_s)
                v = v - lim_s;
        end
        if (v[SW-1])
            return '0;
        else if (v >= lim_s)
            return lim - POS_ONE;
        else
            return v[POS_W-1:0];
    endfunction

    // Form signed movement deltas. An overflow flag saturates the delta to +255 or -256.
    always_comb begin
        dx9 = $signed({PKT_STATUS[4], PKT_DX});
        dy9 = $signed({PKT_STATUS[5], PKT_DY});
        if (PKT_STATUS[6])
            dx9 = PKT_STATUS[4] ? 9'h100 : 9'h0FF;
        if (PKT_STATUS[7])
            dy9 = PKT_STATUS[5] ? 9'h100 : 9'h0FF;
        dx_ext = $signed({{(SW-9){dx9[8]}}, dx9});
        dy_ext = $signed({{(SW-9){dy9[8]}}, dy9});
        x_sum  = $signed({2'b00, x_q}) + dx_ext;
        y_sum  = ctrl_q[2] ? ($signed({2'b00, y_q}) - dy_ext)
                           : ($signed({2'b00, y_q}) + dy_ext);
    end

    // Next-state logic for packets, register writes, the click counter and the interrupt.
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        z_d      = z_q;
        status_d = status_q;
        ctrl_d   = ctrl_q;
        xlim_d   = xlim_q;
        ylim_d   = ylim_q;
        missed_d = missed_q;
        click_d  = click_q;
        raise_d  = raise_q;

        if (PKT_VALID) begin
            status_d = PKT_STATUS[3:0];
            z_d      = z_q + {{4{PKT_DZ[3]}}, PKT_DZ};
            if (PKT_STATUS[2] && ctrl_q[3]) begin
                x_d = xlim_q >> 1;
                y_d = ylim_q >> 1;
            end else begin
                x_d = fit_pos(x_sum, xlim_q, ctrl_q[0]);
                y_d = fit_pos(y_sum, ylim_q, ctrl_q[1]);
            end
            // Count only a left-button press edge seen between consecutive packets.
            if (PKT_STATUS[0] && !status_q[0])
                click_d = (click_q == CLICK_TOP) ? '0 : click_q + CLICK_ONE;
        end

        // A new packet outranks an acknowledge that arrives in the same cycle.
        if (PKT_VALID)
            raise_d = 1'b1;
        else if (BUS_INTERRUPT_ACK)
            raise_d = 1'b0;

        // A software clear beats a simultaneous missed-packet increment.
        if (wr_missed)
            missed_d = '0;
        else if (PKT_VALID && raise_q && !BUS_INTERRUPT_ACK && (missed_q != 8'hFF))
            missed_d = missed_q + 8'd1;

        // Limit writes below 2 are dropped. Positions are left as they are until the next packet.
        if (wr_en) begin
            case (offset[3:0])
                OFF_CTRL:    ctrl_d = BUS_DATA[3:0];
                OFF_XLIM_LO: if (xlim_lo_cand >= LIM_MIN) xlim_d = xlim_lo_cand;
                OFF_XLIM_HI: if (xlim_hi_cand >= LIM_MIN) xlim_d = xlim_hi_cand;
                OFF_YLIM_LO: if (ylim_lo_cand >= LIM_MIN) ylim_d = ylim_lo_cand;
                OFF_YLIM_HI: if (ylim_hi_cand >= LIM_MIN) ylim_d = ylim_hi_cand;
                default:     ;
            endcase
        end
    end

    // Read mux. The selected byte is registered and driven onto the bus on the following cycle.
    always_comb begin
        rd_en_d  = in_win && !BUS_WE;
        rd_dat_d = 8'h00;
        case (offset[3:0])
            OFF_STATUS:  rd_dat_d = {4'h0, status_q};
            OFF_X_LO:    rd_dat_d = x_ext16[7:0];
            OFF_X_HI:    rd_dat_d = x_ext16[15:8];
            OFF_Y_LO:    rd_dat_d = y_ext16[7:0];
            OFF_Y_HI:    rd_dat_d = y_ext16[15:8];
            OFF_Z:       rd_dat_d = z_q;
            OFF_CTRL:    rd_dat_d = {4'h0, ctrl_q};
            OFF_MISSED:  rd_dat_d = missed_q;
            OFF_XLIM_LO: rd_dat_d = xlim_ext16[7:0];
            OFF_XLIM_HI: rd_dat_d = xlim_ext16[15:8];
            OFF_YLIM_LO: rd_dat_d = ylim_ext16[7:0];
            OFF_YLIM_HI: rd_dat_d = ylim_ext16[15:8];
            default:     rd_dat_d = 8'h00;
        endcase
    end

    // State registers. Reset aborts any packet or read in flight.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            x_q      <= X_LIM_RST >> 1;
            y_q      <= Y_LIM_RST >> 1;
            z_q      <= 8'h80;
            status_q <= 4'h0;
            ctrl_q   <= 4'hC;
            xlim_q   <= X_LIM_RST;
            ylim_q   <= Y_LIM_RST;
            missed_q <= 8'h00;
            click_q  <= '0;
            raise_q  <= 1'b0;
            rd_en_q  <= 1'b0;
            rd_dat_q <= 8'h00;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            z_q      <= z_d;
            status_q <= status_d;
            ctrl_q   <= ctrl_d;
            xlim_q   <= xlim_d;
            ylim_q   <= ylim_d;
            missed_q <= missed_d;
            click_q  <= click_d;
            raise_q  <= raise_d;
            rd_en_q  <= rd_en_d;
            rd_dat_q <= rd_dat_d;
        end
    end

    assign BUS_DATA            = rd_en_q ? rd_dat_q : 8'hzz;
    assign BUS_INTERRUPT_RAISE = raise_q;
    assign CLICK_COUNT         = click_q;

endmodule

// File: tb/tb_mouse_position_tracker.sv
// Purpose: directed bench for mouse_position_tracker. It uses a packet vector table plus hand-written multi-cycle sequences.
// Latency: every packet result is read back over the bus one cycle after the packet.
// Backpressure: none. A pull-up on the bus makes a released bus read as 8'hFF.
module tb_mouse_position_tracker;

    logic       clk;
    logic       rst;
    logic       pkt_valid;
    logic [7:0] pkt_status, pkt_dx, pkt_dy;
    logic [3:0] pkt_dz;
    logic [7:0] bus_addr;
    logic       bus_we;
    wire  [7:0] bus_data;
    logic       drv_en;
    logic [7:0] drv_dat;
    logic       irq_raise, irq_ack;
    logic [1:0] click_count;

    int checks = 0;
    int errors = 0;

    pullup pu_bus (bus_data);
    assign bus_data = drv_en ? drv_dat : 8'hzz;

    mouse_position_tracker dut (
        .CLK                 (clk),
        .RESET               (rst),
        .PKT_VALID           (pkt_valid),
        .PKT_STATUS          (pkt_status),
        .PKT_DX              (pkt_dx),
        .PKT_DY              (pkt_dy),
        .PKT_DZ              (pkt_dz),
        .BUS_ADDR            (bus_addr),
        .BUS_WE              (bus_we),
        .BUS_DATA            (bus_data),
        .BUS_INTERRUPT_RAISE (irq_raise),
        .BUS_INTERRUPT_ACK   (irq_ack),
        .CLICK_COUNT         (click_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] st;
        logic [7:0] dx;
        logic [7:0] dy;
        logic [3:0] dz;
        logic [7:0] ex_x;
        logic [7:0] ex_y;
        logic [7:0] ex_z;
        logic [7:0] ex_s;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_pkt(input logic [7:0] st, input logic [7:0] dx, input logic [7:0] dy, input logic [3:0] dz);
        @(negedge clk);
        pkt_valid = 1'b1; pkt_status = st; pkt_dx = dx; pkt_dy = dy; pkt_dz = dz;
        @(negedge clk);
        pkt_valid = 1'b0;
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        bus_addr = a; bus_we = 1'b1; drv_en = 1'b1; drv_dat = d;
        @(negedge clk);
        bus_we = 1'b0; drv_en = 1'b0; bus_addr = 8'h00;
    endtask

    task automatic bus_rd(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        bus_addr = a; bus_we = 1'b0;
        @(negedge clk);
        d = bus_data;
        bus_addr = 8'h00;
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] d;
        bus_rd(a, d);
        check(name, {8'h00, d}, {8'h00, exp});
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
    endtask

    // Bound the whole run, so a stuck bench still reports.
    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] clicks_in[13];
        logic [1:0] clicks_ex[13];
        logic [7:0] d;

        // Fields: status, dx, dy, dz, then the expected X, Y, Z and STATUS.
        vecs[0]  = '{8'h10, 8'hF0, 8'h00, 4'h0, 8'd64,  8'd60,  8'h80, 8'h00};
        vecs[1]  = '{8'h10, 8'hF0, 8'h00, 4'h0, 8'd48,  8'd60,  8'h80, 8'h00};
        vecs[2]  = '{8'h10, 8'hF0, 8'h00, 4'h0, 8'd32,  8'd60,  8'h80, 8'h00};
        vecs[3]  = '{8'h10, 8'hF0, 8'h00, 4'h0, 8'd16,  8'd60,  8'h80, 8'h00};
        vecs[4]  = '{8'h10, 8'hF0, 8'h00, 4'h0, 8'd0,   8'd60,  8'h80, 8'h00};
        vecs[5]  = '{8'h10, 8'hF0, 8'h00, 4'h0, 8'd0,   8'd60,  8'h80, 8'h00};
        vecs[6]  = '{8'h00, 8'h00, 8'h0A, 4'h3, 8'd0,   8'd50,  8'h83, 8'h00};
        vecs[7]  = '{8'h20, 8'h00, 8'hF6, 4'hF, 8'd0,   8'd60,  8'h82, 8'h00};
        vecs[8]  = '{8'h20, 8'h00, 8'h80, 4'h8, 8'd0,   8'd119, 8'h7A, 8'h00};
        vecs[9]  = '{8'h00, 8'h64, 8'h00, 4'h0, 8'd100, 8'd119, 8'h7A, 8'h00};
        vecs[10] = '{8'h40, 8'h00, 8'h00, 4'h0, 8'd159, 8'd119, 8'h7A, 8'h00};
        vecs[11] = '{8'h50, 8'h00, 8'h00, 4'h0, 8'd0,   8'd119, 8'h7A, 8'h00};
        vecs[12] = '{8'h0C, 8'h30, 8'h30, 4'h1, 8'd80,  8'd60,  8'h7B, 8'h0C};
        vecs[13] = '{8'h80, 8'h00, 8'h00, 4'h0, 8'd80,  8'd0,   8'h7B, 8'h00};
        vecs[14] = '{8'h0A, 8'h05, 8'h05, 4'h7, 8'd85,  8'd0,   8'h82, 8'h0A};

        clicks_in = '{8'h08, 8'h09, 8'h09, 8'h08, 8'h09, 8'h08, 8'h09, 8'h08, 8'h09, 8'h08, 8'h09, 8'h08, 8'h09};
        clicks_ex = '{2'd0,  2'd1,  2'd1,  2'd1,  2'd2,  2'd2,  2'd3,  2'd3,  2'd0,  2'd0,  2'd1,  2'd1,  2'd2};

        rst = 1'b1; pkt_valid = 1'b0; pkt_status = 8'h00; pkt_dx = 8'h00; pkt_dy = 8'h00; pkt_dz = 4'h0;
        bus_addr = 8'h00; bus_we = 1'b0; drv_en = 1'b0; drv_dat = 8'h00; irq_ack = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_bus_released", {8'h00, bus_data}, 16'h00FF);
        check("rst_raise", {15'h0, irq_raise}, 16'h0);
        check("rst_click", {14'h0, click_count}, 16'h0);
        rd_chk("rst_x_lo", 8'hA1, 8'h50);
        rd_chk("rst_x_hi", 8'hA2, 8'h3C - 8'h3C);
        @(negedge clk);
        check("rd_release", {8'h00, bus_data}, 16'h00FF);
        rd_chk("rst_y_lo", 8'hA3, 8'h3C);
        rd_chk("rst_status", 8'hA0, 8'h00);
        rd_chk("rst_z", 8'hA5, 8'h80);
        rd_chk("rst_ctrl", 8'hA6, 8'h0C);
        rd_chk("rst_missed", 8'hA7, 8'h00);
        rd_chk("rst_xlim", 8'hA8, 8'hA0);
        rd_chk("rst_xlim_hi", 8'hA9, 8'h00);
        rd_chk("rst_ylim", 8'hAA, 8'h78);

        // Packet vector table
        for (int i = 0; i < 15; i++) begin
            send_pkt(vecs[i].st, vecs[i].dx, vecs[i].dy, vecs[i].dz);
            rd_chk($sformatf("vec%0d_x", i), 8'hA1, vecs[i].ex_x);
            rd_chk($sformatf("vec%0d_y", i), 8'hA3, vecs[i].ex_y);
            rd_chk($sformatf("vec%0d_z", i), 8'hA5, vecs[i].ex_z);
            rd_chk($sformatf("vec%0d_s", i), 8'hA0, vecs[i].ex_s);
        end

        // X wrap mode and limit writes
        bus_wr(8'hA6, 8'h0D);
        rd_chk("ctrl_wr", 8'hA6, 8'h0D);
        send_pkt(8'h10, 8'hB0, 8'h00, 4'h0);
        rd_chk("wrap_x5", 8'hA1, 8'd5);
        send_pkt(8'h10, 8'hF6, 8'h00, 4'h0);
        rd_chk("wrap_neg", 8'hA1, 8'd155);
        bus_wr(8'hA8, 8'h01);
        rd_chk("xlim1_discard", 8'hA8, 8'hA0);
        bus_wr(8'hA8, 8'h00);
        rd_chk("xlim0_discard", 8'hA8, 8'hA0);
        bus_wr(8'hA1, 8'h00);
        rd_chk("ro_write_ignored", 8'hA1, 8'd155);
        send_pkt(8'h00, 8'h0A, 8'h00, 4'h0);
        rd_chk("wrap_pos", 8'hA1, 8'd5);
        bus_wr(8'hA8, 8'h10);
        rd_chk("xlim16", 8'hA8, 8'h10);
        rd_chk("x_kept_on_lim", 8'hA1, 8'd5);
        send_pkt(8'h00, 8'h14, 8'h00, 4'h0);
        rd_chk("wrap_lim16", 8'hA1, 8'd9);
        bus_wr(8'hA8, 8'h04);
        send_pkt(8'h00, 8'h00, 8'h00, 4'h0);
        rd_chk("wrap_then_clamp", 8'hA1, 8'd3);
        bus_wr(8'hA8, 8'hA0);

        // Y without inversion, then a minimum Y limit
        bus_wr(8'hA6, 8'h08);
        send_pkt(8'h00, 8'h00, 8'h0A, 4'h0);
        rd_chk("y_noinv", 8'hA3, 8'd10);
        bus_wr(8'hAA, 8'h02);
        bus_wr(8'hAA, 8'h01);
        rd_chk("ylim2_kept", 8'hAA, 8'h02);
        send_pkt(8'h00, 8'h00, 8'h00, 4'h0);
        rd_chk("y_clamp_lim2", 8'hA3, 8'd1);
        bus_wr(8'hAA, 8'h78);

        // Interrupt and missed-packet counter
        ack_pulse();
        check("ack_clears", {15'h0, irq_raise}, 16'h0);
        bus_wr(8'hA7, 8'h00);
        rd_chk("missed_clr0", 8'hA7, 8'h00);
        repeat (3) send_pkt(8'h08, 8'h00, 8'h00, 4'h0);
        check("raise_set", {15'h0, irq_raise}, 16'h1);
        rd_chk("missed2", 8'hA7, 8'h02);
        @(negedge clk);
        pkt_valid = 1'b1; pkt_status = 8'h08; pkt_dx = 8'h00; pkt_dy = 8'h00; pkt_dz = 4'h0; irq_ack = 1'b1;
        @(negedge clk);
        pkt_valid = 1'b0; irq_ack = 1'b0;
        check("raise_wins", {15'h0, irq_raise}, 16'h1);
        rd_chk("missed_ack_same", 8'hA7, 8'h02);
        bus_wr(8'hA7, 8'h55);
        rd_chk("missed_clr", 8'hA7, 8'h00);
        @(negedge clk);
        pkt_valid = 1'b1; pkt_status = 8'h08;
        bus_addr = 8'hA7; bus_we = 1'b1; drv_en = 1'b1; drv_dat = 8'h00;
        @(negedge clk);
        pkt_valid = 1'b0; bus_we = 1'b0; drv_en = 1'b0; bus_addr = 8'h00;
        rd_chk("clear_wins", 8'hA7, 8'h00);
        repeat (300) send_pkt(8'h08, 8'h00, 8'h00, 4'h0);
        rd_chk("missed_sat", 8'hA7, 8'hFF);
        bus_wr(8'hA7, 8'h00);

        // Left-click press edges, wrapping at modulus 4
        for (int i = 0; i < 13; i++) begin
            send_pkt(clicks_in[i], 8'h00, 8'h00, 4'h0);
            check($sformatf("click%0d", i), {14'h0, click_count}, {14'h0, clicks_ex[i]});
        end

        // Reset during a packet and a bus read
        @(negedge clk);
        pkt_valid = 1'b1; pkt_status = 8'h41; pkt_dx = 8'h20; pkt_dz = 4'h5;
        bus_addr = 8'hA1; bus_we = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
        pkt_valid = 1'b0; bus_addr = 8'h00;
        check("rst_mid_bus", {8'h00, bus_data}, 16'h00FF);
        check("rst_mid_raise", {15'h0, irq_raise}, 16'h0);
        check("rst_mid_click", {14'h0, click_count}, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        rd_chk("rst_mid_x", 8'hA1, 8'h50);
        rd_chk("rst_mid_y", 8'hA3, 8'h3C);
        rd_chk("rst_mid_z", 8'hA5, 8'h80);
        rd_chk("rst_mid_s", 8'hA0, 8'h00);
        rd_chk("rst_mid_ctrl", 8'hA6, 8'h0C);
        rd_chk("rst_mid_xlim", 8'hA8, 8'hA0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
